wb_mtimer: RTL and testbench
============================

Name: wb_mtimer

Overview:
- Wishbone B4 pipelined slave (responder) implementing the RISC-V machine timer: 64-bit mtime and 64-bit mtimecmp, plus a prescaler/control register.
- Sits on the data bus fabric behind the core's LSU Wishbone master.
- Drives the level-sensitive machine timer interrupt into the core's irq_timer_i input.

Parameters:
- RST_DIV, 8'd0, reset value of CTRL.div (prescaler divide-minus-one).
- RST_EN, 1'b0, reset value of CTRL.en.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset, asynchronous, active-high.
- wb_cyc_i  in  1  bus cycle active.
- wb_stb_i  in  1  request strobe.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  32  byte address; only [4:2] are decoded, others ignored.
- wb_sel_i  in  4  byte lane enables for writes.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid with wb_ack_o.
- wb_ack_o  out  1  transfer acknowledge.
- wb_stall_o  out  1  constant 0; a request is accepted every cycle.
- irq_timer_o  out  1  machine timer interrupt, connects to core irq_timer_i.

Behaviour:
- Reset (async, rst_i=1):
  - mtime = 0.
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - CTRL.en = RST_EN, CTRL.div = RST_DIV, prescaler count = 0.
  - wb_ack_o = 0, wb_dat_o = 0, irq_timer_o = 0.
- Register map (wb_adr_i[4:2]):
  - 0 MTIME_LO.
  - 1 MTIME_HI.
  - 2 MTIMECMP_LO.
  - 3 MTIMECMP_HI.
  - 4 CTRL: bit0 en, bits[15:8] div, other bits read 0.
  - 5..7 unmapped: read 0, writes ignored, still acked.
- Accept: wb_cyc_i & wb_stb_i (stall is 0) in cycle N.
- Ack timing:
  - wb_ack_o = 1 in cycle N+1 with registered wb_dat_o.
  - Back-to-back requests give back-to-back acks, exactly one ack per accepted request.
  - No error response.
- Read data is the register value sampled in cycle N, before any same-cycle update.
- Writes commit at the clock edge ending cycle N.
  - Merge is per byte: byte i written iff wb_sel_i[i]; unselected bytes hold their value.
- Abort: if wb_cyc_i is 0 in cycle N+1, the pending ack is suppressed (wb_ack_o = 0). The write side effect is already committed.
- Prescaler, when CTRL.en = 1:
  - Each cycle: if cnt == CTRL.div, then cnt <= 0 and mtime <= mtime + 1 (full 64-bit, carry LO→HI); otherwise cnt <= cnt + 1.
  - div = 0 gives a tick every cycle; div = 255 gives a tick every 256 cycles.
- When CTRL.en = 0: cnt and mtime hold.
- A write to CTRL forces cnt <= 0 that cycle.
- Simultaneous bus write to MTIME_LO or MTIME_HI and a tick:
  - The write wins for the written half.
  - The other half holds; no increment that cycle, so no carry propagates.
- mtime wraps from 2^64-1 to 0 silently.
- Interrupt:
  - irq_timer_o <= (mtime >= mtimecmp), unsigned 64-bit, registered every cycle.
  - Independent of CTRL.en.
  - Level signal: deasserts one cycle after software raises mtimecmp above mtime or lowers mtime.
- Software reads mtime as HI, LO, HI and retries on HI mismatch; the hardware provides no shadow latch.

Decomposition:
- Shared package holds:
  - Register offset localparams MTIMER_MTIME_LO..MTIMER_CTRL.
  - packed struct mtimer_ctrl_t {div[7:0], en}.
  - MTIMECMP reset constant.
- One sub-module is natural: wb_slave_regif, the generic single-cycle-ack pipelined Wishbone slave front end.
  - Handles accept, ack register, abort and byte merge.
  - Outputs reg_we/reg_re/reg_idx/reg_wdata/reg_wmask and takes reg_rdata.
  - Reusable by later peripherals.
- Timer datapath lives in wb_mtimer.

Test Plan:
- Reset check: assert rst_i mid-operation → all outputs 0 asynchronously. After release, read MTIMECMP_LO/HI → 0xFFFFFFFF/0xFFFFFFFF, MTIME → 0, irq_timer_o = 0.
- Compare and interrupt:
  - Write MTIMECMP_HI=0, MTIMECMP_LO=10, then CTRL=0x1 → mtime counts one per cycle.
  - irq_timer_o rises the cycle after mtime reaches 10.
  - Write MTIMECMP_LO=0x100 → irq_timer_o falls one cycle after the commit.
- Carry, write priority and prescaler:
  - Write MTIME_HI=0, MTIME_LO=0xFFFFFFFF with en=1, div=0 → next tick gives HI=1, LO=0.
  - A write to MTIME_LO in the same cycle as a tick stores the written value, not value+1.
  - CTRL=0x0301 (div=3) → mtime increments exactly every 4 cycles; writing CTRL restarts the count.
- Byte select: write MTIMECMP_LO=0xAABBCCDD with wb_sel_i=4'b0101 over 0xFFFFFFFF → reads 0xFFBBFFDD.
- Pipelining and abort:
  - Three consecutive read strobes to indices 4, 2, 5 → acks in 3 consecutive cycles with data CTRL, MTIMECMP_LO, 0.
  - Drop wb_cyc_i the cycle after a write strobe → no ack, write still visible on a later read.

Source files
------------

// File: rtl/wb_mtimer_pkg.sv
// Shared definitions for the RISC-V machine timer: register offsets,
// control register layout and reset constants.
package wb_mtimer_pkg;

  // Word offsets decoded from wb_adr_i[4:2]
  localparam logic [2:0] MTIMER_MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIMER_MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMER_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMER_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] MTIMER_CTRL        = 3'd4;

  // CTRL register: div at bits [15:8], en at bit 0
  typedef struct packed {
    logic [7:0] div;
    logic       en;
  } mtimer_ctrl_t;

  // mtimecmp starts at all-ones so the interrupt stays quiet out of reset
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Byte-lane merge: bits under wmask take wdata, the rest keep old
  function automatic logic [31:0] merge_word(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [31:0] wmask);
    return (old & ~wmask) | (wdata & wmask);
  endfunction

  // Bus view of the control register
  function automatic logic [31:0] ctrl_to_word(input mtimer_ctrl_t c);
    return {16'h0000, c.div, 7'h00, c.en};
  endfunction

endpackage

// File: rtl/wb_slave_regif.sv
// Generic Wishbone B4 pipelined slave front end: never stalls, acks every
// accepted request one cycle later, and presents a simple register strobe
// interface with a bit-level write mask derived from the byte selects.
module wb_slave_regif (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        ack,
  output logic        stall,
  output logic        reg_we,
  output logic        reg_re,
  output logic [2:0]  reg_idx,
  output logic [31:0] reg_wdata,
  output logic [31:0] reg_wmask,
  input  logic [31:0] reg_rdata
);

  logic        accept;
  logic        ack_q;
  logic [31:0] rdata_q;
  logic        unused_adr;

  assign unused_adr = ^{adr[31:5], adr[1:0]};

  // Request decode: a strobe inside an active cycle is taken immediately
  always_comb begin
    accept    = cyc & stb;
    reg_we    = accept & we;
    reg_re    = accept & ~we;
    reg_idx   = adr[4:2];
    reg_wdata = bus_wdata;
    reg_wmask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  end

  // Ack and read data are registered one cycle after acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= accept;
      if (accept) rdata_q <= reg_rdata;
    end
  end

  // Dropping cyc in the ack cycle aborts the transfer, so the ack is gated
  always_comb begin
    ack       = ack_q & cyc;
    bus_rdata = rdata_q;
    stall     = 1'b0;
  end

endmodule

// File: rtl/wb_mtimer.sv
// RISC-V machine timer behind a Wishbone pipelined slave: 64-bit mtime with
// a programmable prescaler, 64-bit mtimecmp and a level timer interrupt.
module wb_mtimer
  import wb_mtimer_pkg::*;
#(
  parameter logic [7:0] RST_DIV = 8'd0,
  parameter logic       RST_EN  = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  output logic        irq_timer_o
);

  logic         reg_we;
  logic         reg_re;
  logic [2:0]   reg_idx;
  logic [31:0]  reg_wdata;
  logic [31:0]  reg_wmask;
  logic [31:0]  reg_rdata;

  logic [63:0]  mtime;
  logic [63:0]  mtimecmp;
  mtimer_ctrl_t ctrl;
  logic [7:0]   cnt;
  logic         irq;

  logic         wr_mtime_lo;
  logic         wr_mtime_hi;
  logic         wr_cmp_lo;
  logic         wr_cmp_hi;
  logic         wr_ctrl;
  logic         tick;

  wb_slave_regif u_regif (
    .clk       (clk_i),
    .rst       (rst_i),
    .cyc       (wb_cyc_i),
    .stb       (wb_stb_i),
    .we        (wb_we_i),
    .adr       (wb_adr_i),
    .sel       (wb_sel_i),
    .bus_wdata (wb_dat_i),
    .bus_rdata (wb_dat_o),
    .ack       (wb_ack_o),
    .stall     (wb_stall_o),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_idx   (reg_idx),
    .reg_wdata (reg_wdata),
    .reg_wmask (reg_wmask),
    .reg_rdata (reg_rdata)
  );

  // Write strobes per register and the prescaler tick
  always_comb begin
    wr_mtime_lo = reg_we && (reg_idx == MTIMER_MTIME_LO);
    wr_mtime_hi = reg_we && (reg_idx == MTIMER_MTIME_HI);
    wr_cmp_lo   = reg_we && (reg_idx == MTIMER_MTIMECMP_LO);
    wr_cmp_hi   = reg_we && (reg_idx == MTIMER_MTIMECMP_HI);
    wr_ctrl     = reg_we && (reg_idx == MTIMER_CTRL);
    tick        = ctrl.en && (cnt == ctrl.div);
  end

  // Read mux: values are sampled before any update at the closing edge
  always_comb begin
    reg_rdata = '0;
    if (reg_re) begin
      case (reg_idx)
        MTIMER_MTIME_LO:    reg_rdata = mtime[31:0];
        MTIMER_MTIME_HI:    reg_rdata = mtime[63:32];
        MTIMER_MTIMECMP_LO: reg_rdata = mtimecmp[31:0];
        MTIMER_MTIMECMP_HI: reg_rdata = mtimecmp[63:32];
        MTIMER_CTRL:        reg_rdata = ctrl_to_word(ctrl);
        default:            reg_rdata = '0;
      endcase
    end
  end

  // Control register with per-byte merge of en (byte 0) and div (byte 1)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl.en  <= RST_EN;
      ctrl.div <= RST_DIV;
    end else if (wr_ctrl) begin
      ctrl.en  <= reg_wmask[0] ? reg_wdata[0] : ctrl.en;
      ctrl.div <= (ctrl.div & ~reg_wmask[15:8]) | (reg_wdata[15:8] & reg_wmask[15:8]);
    end
  end

  // Prescaler counter: restarts on any CTRL write, wraps at div
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (wr_ctrl) begin
      cnt <= '0;
    end else if (ctrl.en) begin
      cnt <= tick ? '0 : cnt + 8'd1;
    end
  end

  // mtime: a bus write to either half suppresses that cycle's increment,
  // so the untouched half holds and no carry crosses into it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime <= '0;
    end else if (wr_mtime_lo || wr_mtime_hi) begin
      if (wr_mtime_lo) mtime[31:0]  <= merge_word(mtime[31:0], reg_wdata, reg_wmask);
      if (wr_mtime_hi) mtime[63:32] <= merge_word(mtime[63:32], reg_wdata, reg_wmask);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // mtimecmp halves, byte-merged
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtimecmp <= MTIMECMP_RST;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= merge_word(mtimecmp[31:0], reg_wdata, reg_wmask);
      if (wr_cmp_hi) mtimecmp[63:32] <= merge_word(mtimecmp[63:32], reg_wdata, reg_wmask);
    end
  end

  // Registered level interrupt, independent of the enable
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq <= 1'b0;
    else       irq <= (mtime >= mtimecmp);
  end

  assign irq_timer_o = irq;

endmodule

// File: tb/tb_wb_mtimer.sv
// Self-checking bench for wb_mtimer: a cycle-level model of the timer's
// programmer-visible state predicts ack, read data and interrupt each cycle.
module tb_wb_mtimer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_stall_o, irq_timer_o;

  always #5 clk = ~clk;

  wb_mtimer #(.RST_DIV(8'd0), .RST_EN(1'b0)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_adr_i    (wb_adr_i),
    .wb_sel_i    (wb_sel_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .wb_stall_o  (wb_stall_o),
    .irq_timer_o (irq_timer_o)
  );

  typedef struct packed {
    logic        c;
    logic        s;
    logic        w;
    logic [2:0]  idx;
    logic [3:0]  sel;
    logic [31:0] dat;
  } op_t;

  int n_cmp;
  int n_err;

  // Reference model state
  logic [63:0] m_mtime, m_cmp;
  logic        m_en;
  logic [7:0]  m_div;
  int unsigned m_cnt;
  logic        m_irq;
  logic        pend, pend_rd;
  logic [31:0] pend_dat;

  // Per-cycle expectations and observations
  logic        exp_ack, exp_rd, exp_irq, obs_ack, obs_irq;
  logic [31:0] exp_dat, obs_dat;

  function automatic op_t wr(input logic [2:0] idx, input logic [3:0] sel, input logic [31:0] dat);
    return '{c: 1'b1, s: 1'b1, w: 1'b1, idx: idx, sel: sel, dat: dat};
  endfunction

  function automatic op_t rd(input logic [2:0] idx);
    return '{c: 1'b1, s: 1'b1, w: 1'b0, idx: idx, sel: 4'h0, dat: 32'h0};
  endfunction

  function automatic op_t nop();
    return '{c: 1'b1, s: 1'b0, w: 1'b0, idx: 3'd0, sel: 4'h0, dat: 32'h0};
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] idx);
    case (idx)
      3'd0: return m_mtime[31:0];
      3'd1: return m_mtime[63:32];
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {16'h0, m_div, 7'h0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mtime = 64'h0; m_cmp = '1; m_en = 1'b0; m_div = 8'h0; m_cnt = 0;
    m_irq = 1'b0; pend = 1'b0; pend_rd = 1'b0; pend_dat = 32'h0;
  endtask

  // One bus cycle: drive, sample outputs mid-cycle, advance model to next edge
  task automatic drive(input op_t o);
    logic [31:0] a, rdv;
    logic acc, tick, wen;
    a = $urandom;
    a[4:2] = o.idx;
    wb_cyc_i = o.c; wb_stb_i = o.s; wb_we_i = o.w;
    wb_adr_i = a; wb_sel_i = o.sel; wb_dat_i = o.dat;
    #1;
    obs_ack = wb_ack_o; obs_dat = wb_dat_o; obs_irq = irq_timer_o;
    exp_ack = pend && o.c; exp_rd = pend_rd; exp_dat = pend_dat; exp_irq = m_irq;
    acc  = o.c && o.s;
    wen  = acc && o.w;
    rdv  = m_read(o.idx);
    tick = m_en && (m_cnt == 32'(m_div));
    m_irq = (m_mtime >= m_cmp);
    if (wen && o.idx == 3'd4) m_cnt = 0;
    else if (m_en) m_cnt = tick ? 0 : m_cnt + 1;
    if (wen && o.idx == 3'd0)      m_mtime[31:0]  = bmerge(m_mtime[31:0], o.dat, o.sel);
    else if (wen && o.idx == 3'd1) m_mtime[63:32] = bmerge(m_mtime[63:32], o.dat, o.sel);
    else if (tick)                 m_mtime = m_mtime + 64'd1;
    if (wen && o.idx == 3'd2) m_cmp[31:0]  = bmerge(m_cmp[31:0], o.dat, o.sel);
    if (wen && o.idx == 3'd3) m_cmp[63:32] = bmerge(m_cmp[63:32], o.dat, o.sel);
    if (wen && o.idx == 3'd4) begin
      if (o.sel[0]) m_en  = o.dat[0];
      if (o.sel[1]) m_div = o.dat[15:8];
    end
    pend = acc; pend_rd = acc && !o.w; pend_dat = rdv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    op_t ops[$];
    logic [31:0] want[4];
    model_reset();
    #1;
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL por_ack got %b want 0", wb_ack_o); end
    n_cmp++; if (wb_dat_o !== 32'h0) begin n_err++; $display("FAIL por_dat got %h want 0", wb_dat_o); end
    n_cmp++; if (irq_timer_o !== 1'b0) begin n_err++; $display("FAIL por_irq got %b want 0", irq_timer_o); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Reset values of cmp and mtime read back over the bus
    ops = '{rd(3'd2), rd(3'd3), rd(3'd0), rd(3'd1), nop()};
    want = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    foreach (ops[k]) begin
      drive(ops[k]);
      n_cmp++; if (obs_ack !== (k > 0)) begin n_err++; $display("FAIL rst_read_ack[%0d] got %b want %b", k, obs_ack, k > 0); end
      if (k > 0) begin
        n_cmp++; if (obs_dat !== want[k-1]) begin n_err++; $display("FAIL rst_read_dat[%0d] got %h want %h", k, obs_dat, want[k-1]); end
      end
      n_cmp++; if (obs_irq !== 1'b0) begin n_err++; $display("FAIL rst_irq[%0d] got %b want 0", k, obs_irq); end
    end
    // Get the timer running with irq high and a read in flight, then reset
    ops = '{wr(3'd3, 4'hF, 32'h0), wr(3'd2, 4'hF, 32'h0), wr(3'd4, 4'hF, 32'h1),
            nop(), nop(), nop(), rd(3'd0)};
    foreach (ops[k]) drive(ops[k]);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b0;
    #1;
    n_cmp++; if (wb_ack_o !== 1'b1) begin n_err++; $display("FAIL pre_rst_ack got %b want 1", wb_ack_o); end
    n_cmp++; if (wb_dat_o !== pend_dat) begin n_err++; $display("FAIL pre_rst_dat got %h want %h", wb_dat_o, pend_dat); end
    n_cmp++; if (irq_timer_o !== 1'b1) begin n_err++; $display("FAIL pre_rst_irq got %b want 1", irq_timer_o); end
    rst = 1'b1;
    #1;
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL async_rst_ack got %b want 0", wb_ack_o); end
    n_cmp++; if (wb_dat_o !== 32'h0) begin n_err++; $display("FAIL async_rst_dat got %h want 0", wb_dat_o); end
    n_cmp++; if (irq_timer_o !== 1'b0) begin n_err++; $display("FAIL async_rst_irq got %b want 0", irq_timer_o); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_compare_irq();
    op_t ops[$];
    ops = '{wr(3'd3, 4'hF, 32'h0), wr(3'd2, 4'hF, 32'd10), wr(3'd4, 4'hF, 32'h1)};
    for (int i = 0; i < 16; i++) ops.push_back((i % 2 == 0) ? nop() : rd(3'd0));
    ops.push_back(wr(3'd2, 4'hF, 32'h100));
    for (int i = 0; i < 4; i++) ops.push_back(nop());
    foreach (ops[k]) begin
      drive(ops[k]);
      n_cmp++; if (obs_ack !== exp_ack) begin n_err++; $display("FAIL cmp_ack[%0d] got %b want %b", k, obs_ack, exp_ack); end
      if (exp_ack && exp_rd) begin
        n_cmp++; if (obs_dat !== exp_dat) begin n_err++; $display("FAIL cmp_dat[%0d] got %h want %h", k, obs_dat, exp_dat); end
      end
      n_cmp++; if (obs_irq !== exp_irq) begin n_err++; $display("FAIL cmp_irq[%0d] got %b want %b", k, obs_irq, exp_irq); end
    end
  endtask

  task automatic test_carry_prescaler();
    op_t ops[$];
    ops = '{wr(3'd4, 4'hF, 32'h1), wr(3'd1, 4'hF, 32'h0), wr(3'd0, 4'hF, 32'hFFFF_FFFF),
            rd(3'd1), rd(3'd0), rd(3'd1), wr(3'd0, 4'hF, 32'h1234_5678), rd(3'd0), nop(),
            wr(3'd4, 4'hF, 32'h0000_0301)};
    for (int i = 0; i < 12; i++) ops.push_back(rd(3'd0));
    ops.push_back(wr(3'd4, 4'hF, 32'h0000_0301));
    for (int i = 0; i < 12; i++) ops.push_back(rd(3'd0));
    ops.push_back(nop());
    foreach (ops[k]) begin
      drive(ops[k]);
      n_cmp++; if (obs_ack !== exp_ack) begin n_err++; $display("FAIL carry_ack[%0d] got %b want %b", k, obs_ack, exp_ack); end
      if (exp_ack && exp_rd) begin
        n_cmp++; if (obs_dat !== exp_dat) begin n_err++; $display("FAIL carry_dat[%0d] got %h want %h", k, obs_dat, exp_dat); end
      end
      n_cmp++; if (obs_irq !== exp_irq) begin n_err++; $display("FAIL carry_irq[%0d] got %b want %b", k, obs_irq, exp_irq); end
    end
  endtask

  task automatic test_byte_select();
    op_t ops[$];
    ops = '{wr(3'd2, 4'hF, 32'hFFFF_FFFF), wr(3'd2, 4'b0101, 32'hAABB_CCDD), rd(3'd2), nop()};
    foreach (ops[k]) begin
      drive(ops[k]);
      n_cmp++; if (obs_ack !== exp_ack) begin n_err++; $display("FAIL bsel_ack[%0d] got %b want %b", k, obs_ack, exp_ack); end
      if (k == 3) begin
        n_cmp++; if (obs_dat !== 32'hFFBB_FFDD) begin n_err++; $display("FAIL bsel_dat got %h want ffbbffdd", obs_dat); end
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    int acks;
    acks = 0;
    ops = '{rd(3'd4), rd(3'd2), rd(3'd5), nop(), nop()};
    foreach (ops[k]) begin
      drive(ops[k]);
      if (obs_ack === 1'b1) acks++;
      n_cmp++; if (obs_ack !== exp_ack) begin n_err++; $display("FAIL b2b_ack[%0d] got %b want %b", k, obs_ack, exp_ack); end
      if (exp_ack && exp_rd) begin
        n_cmp++; if (obs_dat !== exp_dat) begin n_err++; $display("FAIL b2b_dat[%0d] got %h want %h", k, obs_dat, exp_dat); end
      end
    end
    n_cmp++; if (acks != 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", acks); end
  endtask

  task automatic test_abort();
    op_t ops[$];
    logic [31:0] v;
    v = $urandom;
    ops = '{wr(3'd3, 4'hF, v), '{c: 1'b0, s: 1'b0, w: 1'b0, idx: 3'd0, sel: 4'h0, dat: 32'h0},
            nop(), rd(3'd3), nop()};
    foreach (ops[k]) begin
      drive(ops[k]);
      n_cmp++; if (obs_ack !== exp_ack) begin n_err++; $display("FAIL abort_ack[%0d] got %b want %b", k, obs_ack, exp_ack); end
      if (k == 4) begin
        n_cmp++; if (obs_dat !== v) begin n_err++; $display("FAIL abort_dat got %h want %h", obs_dat, v); end
      end
    end
  endtask

  task automatic test_random();
    op_t o;
    for (int k = 0; k < 400; k++) begin
      o.c   = ($urandom_range(0, 7) != 0);
      o.s   = $urandom_range(0, 1);
      o.w   = ($urandom_range(0, 3) == 0);
      o.idx = 3'($urandom_range(0, 7));
      o.sel = 4'($urandom);
      o.dat = (o.idx == 3'd4) ? {16'($urandom), 8'($urandom_range(0, 3)), 8'($urandom)} : $urandom;
      drive(o);
      n_cmp++; if (obs_ack !== exp_ack) begin n_err++; $display("FAIL rand_ack[%0d] got %b want %b", k, obs_ack, exp_ack); end
      if (exp_ack && exp_rd) begin
        n_cmp++; if (obs_dat !== exp_dat) begin n_err++; $display("FAIL rand_dat[%0d] got %h want %h", k, obs_dat, exp_dat); end
      end
      n_cmp++; if (obs_irq !== exp_irq) begin n_err++; $display("FAIL rand_irq[%0d] got %b want %b", k, obs_irq, exp_irq); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 32'h0; wb_sel_i = 4'h0; wb_dat_i = 32'h0;
    test_reset();
    test_compare_irq();
    test_carry_prescaler();
    test_byte_select();
    test_back_to_back();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
